// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like port arbiter: requester IDs and grant encodings.
package sram_like_arbiter_pkg;

    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    typedef enum logic [1:0] {
        GRANT_IDLE      = 2'd0,
        GRANT_HOLD_INST = 2'd1,
        GRANT_HOLD_DATA = 2'd2
    } grant_state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_INST = 2'd1,
        SEL_DATA = 2'd2
    } grant_sel_t;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like channel: request fields from master, handshake/response from slave.
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter_order_fifo.sv
// In-order record of which requester issued each accepted, still-unanswered request.
module arb_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head_id,
    output logic empty,
    output logic full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] ids;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // Both guards use registered state, so a pop never frees a slot for a same-cycle push.
    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = ids[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            ids    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                ids[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end
endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between fetch and load/store, data side first,
// and steers each in-order response back to the requester that issued it.
//
// state           | meaning
// GRANT_IDLE      | no committed grant; pick data, else inst, this cycle
// GRANT_HOLD_INST | inst granted but not yet accepted; grant locked to inst
// GRANT_HOLD_DATA | data granted but not yet accepted; grant locked to data
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int ORDER_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    sram_like_arbiter_if.slave  inst,
    sram_like_arbiter_if.slave  data,
    sram_like_arbiter_if.master mem
);
    grant_state_t state;
    grant_state_t state_nxt;
    grant_sel_t   sel;

    logic        sel_req;
    logic        sel_wr;
    logic [1:0]  sel_size;
    logic [3:0]  sel_wstrb;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        mem_req_int;
    logic        handshake;

    logic fifo_head_id;
    logic fifo_empty;
    logic fifo_full;
    logic resp_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= GRANT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        sel       = SEL_NONE;
        state_nxt = state;
        sel_req   = 1'b0;
        sel_wr    = 1'b0;
        sel_size  = '0;
        sel_wstrb = '0;
        sel_addr  = '0;
        sel_wdata = '0;

        case (state)
            GRANT_IDLE: begin
                if (data.req) begin
                    sel = SEL_DATA;
                end else if (inst.req) begin
                    sel = SEL_INST;
                end
            end
            GRANT_HOLD_INST: sel = SEL_INST;
            GRANT_HOLD_DATA: sel = SEL_DATA;
            default:         sel = SEL_NONE;
        endcase

        case (sel)
            SEL_INST: begin
                sel_req   = inst.req;
                sel_wr    = inst.wr;
                sel_size  = inst.size;
                sel_wstrb = inst.wstrb;
                sel_addr  = inst.addr;
                sel_wdata = inst.wdata;
            end
            SEL_DATA: begin
                sel_req   = data.req;
                sel_wr    = data.wr;
                sel_size  = data.size;
                sel_wstrb = data.wstrb;
                sel_addr  = data.addr;
                sel_wdata = data.wdata;
            end
            default: ;
        endcase

        mem_req_int = sel_req && !fifo_full && !reset;
        handshake   = mem_req_int && mem.addr_ok;

        // A grant that is not accepted this cycle (bridge busy or FIFO full) is locked in.
        case (sel)
            SEL_INST: state_nxt = handshake ? GRANT_IDLE : GRANT_HOLD_INST;
            SEL_DATA: state_nxt = handshake ? GRANT_IDLE : GRANT_HOLD_DATA;
            default:  state_nxt = GRANT_IDLE;
        endcase
    end

    assign mem.req   = mem_req_int;
    assign mem.wr    = sel_wr;
    assign mem.size  = sel_size;
    assign mem.wstrb = sel_wstrb;
    assign mem.addr  = sel_addr;
    assign mem.wdata = sel_wdata;

    assign inst.addr_ok = handshake && (sel == SEL_INST);
    assign data.addr_ok = handshake && (sel == SEL_DATA);

    arb_order_fifo #(
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (handshake),
        .push_id ((sel == SEL_DATA) ? ARB_ID_DATA : ARB_ID_INST),
        .pop     (mem.data_ok && !reset),
        .head_id (fifo_head_id),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // A stray data_ok with nothing outstanding belongs to nobody.
    assign resp_valid   = mem.data_ok && !fifo_empty && !reset;
    assign inst.data_ok = resp_valid && (fifo_head_id == ARB_ID_INST);
    assign data.data_ok = resp_valid && (fifo_head_id == ARB_ID_DATA);
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: inputs driven 1 ns after posedge, outputs checked 4 ns after.
module tb_sram_like_arbiter;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    sram_like_arbiter_if inst_bus ();
    sram_like_arbiter_if data_bus ();
    sram_like_arbiter_if mem_bus ();

    sram_like_arbiter #(.ORDER_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .inst  (inst_bus),
        .data  (data_bus),
        .mem   (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic idle_all();
        inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
        inst_bus.wstrb = 4'h0; inst_bus.addr = 32'h0; inst_bus.wdata = 32'h0;
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd2;
        data_bus.wstrb = 4'h0; data_bus.addr = 32'h0; data_bus.wdata = 32'h0;
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = 32'h0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_all();
        reset = 1'b1;
        tick();

        // Reset holds everything quiet even with live requests and responses.
        inst_bus.req = 1'b1; inst_bus.addr = 32'hbfc0_0000;
        mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1;
        settle();
        chk("rst_mem_req", mem_bus.req, 0);
        chk("rst_inst_addr_ok", inst_bus.addr_ok, 0);
        chk("rst_inst_data_ok", inst_bus.data_ok, 0);
        chk("rst_data_data_ok", data_bus.data_ok, 0);
        chk("rst_fifo_empty", dut.fifo_empty, 1);
        tick();
        idle_all();
        reset = 1'b0;
        tick();

        // Lone inst read.
        inst_bus.req = 1'b1; inst_bus.addr = 32'hbfc0_0000; mem_bus.addr_ok = 1'b1;
        settle();
        chk("lone_mem_req", mem_bus.req, 1);
        chk("lone_mem_addr", mem_bus.addr, 32'hbfc0_0000);
        chk("lone_inst_addr_ok", inst_bus.addr_ok, 1);
        chk("lone_data_addr_ok", data_bus.addr_ok, 0);
        tick();
        idle_all();
        settle();
        chk("lone_no_early_data_ok", inst_bus.data_ok, 0);
        chk("lone_mem_fields_zero", mem_bus.addr, 32'h0);
        tick();
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h3c08_bfc0;
        settle();
        chk("lone_inst_data_ok", inst_bus.data_ok, 1);
        chk("lone_inst_rdata", inst_bus.rdata, 32'h3c08_bfc0);
        chk("lone_data_data_ok", data_bus.data_ok, 0);
        tick();
        // FIFO now empty: this data_ok is stray.
        settle();
        chk("stray_inst_data_ok", inst_bus.data_ok, 0);
        chk("stray_data_data_ok", data_bus.data_ok, 0);
        chk("stray_fifo_empty", dut.fifo_empty, 1);
        tick();
        idle_all();

        // Collision: data wins, inst follows next cycle.
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0040_0000;
        data_bus.req = 1'b1; data_bus.addr = 32'h8000_1000; data_bus.wr = 1'b1;
        data_bus.wstrb = 4'hf; data_bus.wdata = 32'hdead_beef;
        mem_bus.addr_ok = 1'b1;
        settle();
        chk("coll_mem_addr", mem_bus.addr, 32'h8000_1000);
        chk("coll_mem_wr", mem_bus.wr, 1);
        chk("coll_mem_wdata", mem_bus.wdata, 32'hdead_beef);
        chk("coll_mem_wstrb", mem_bus.wstrb, 4'hf);
        chk("coll_data_addr_ok", data_bus.addr_ok, 1);
        chk("coll_inst_addr_ok", inst_bus.addr_ok, 0);
        tick();
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.wstrb = 4'h0; data_bus.wdata = 32'h0;
        settle();
        chk("coll_next_mem_addr", mem_bus.addr, 32'h0040_0000);
        chk("coll_next_inst_addr_ok", inst_bus.addr_ok, 1);
        tick();
        idle_all();
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0;
        settle();
        chk("coll_resp1_data", data_bus.data_ok, 1);
        chk("coll_resp1_inst", inst_bus.data_ok, 0);
        tick();
        settle();
        chk("coll_resp2_inst", inst_bus.data_ok, 1);
        chk("coll_resp2_data", data_bus.data_ok, 0);
        tick();
        idle_all();

        // Hold: inst granted while bridge is busy, data arrives later and must wait.
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0040_0010;
        settle();
        chk("hold_c1_mem_addr", mem_bus.addr, 32'h0040_0010);
        chk("hold_c1_inst_addr_ok", inst_bus.addr_ok, 0);
        tick();
        data_bus.req = 1'b1; data_bus.addr = 32'h8000_2000;
        settle();
        chk("hold_c2_mem_addr", mem_bus.addr, 32'h0040_0010);
        chk("hold_c2_data_addr_ok", data_bus.addr_ok, 0);
        tick();
        settle();
        chk("hold_c3_mem_addr", mem_bus.addr, 32'h0040_0010);
        tick();
        mem_bus.addr_ok = 1'b1;
        settle();
        chk("hold_c4_inst_addr_ok", inst_bus.addr_ok, 1);
        chk("hold_c4_data_addr_ok", data_bus.addr_ok, 0);
        tick();
        inst_bus.req = 1'b0;
        settle();
        chk("hold_data_mem_addr", mem_bus.addr, 32'h8000_2000);
        chk("hold_data_addr_ok", data_bus.addr_ok, 1);
        tick();
        idle_all();
        mem_bus.data_ok = 1'b1;
        settle();
        chk("hold_resp1_inst", inst_bus.data_ok, 1);
        tick();
        settle();
        chk("hold_resp2_data", data_bus.data_ok, 1);
        tick();
        idle_all();

        // Ordering: inst, data, inst back-to-back, responses steered in order.
        inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_0100; mem_bus.addr_ok = 1'b1;
        settle();
        chk("ord_a_inst_addr_ok", inst_bus.addr_ok, 1);
        tick();
        inst_bus.req = 1'b0; data_bus.req = 1'b1; data_bus.addr = 32'h8000_0200;
        settle();
        chk("ord_b_data_addr_ok", data_bus.addr_ok, 1);
        tick();
        data_bus.req = 1'b0; inst_bus.req = 1'b1; inst_bus.addr = 32'h0000_0104;
        settle();
        chk("ord_c_inst_addr_ok", inst_bus.addr_ok, 1);
        tick();
        idle_all();
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'd1;
        settle();
        chk("ord_r1_inst", inst_bus.data_ok, 1);
        chk("ord_r1_rdata", inst_bus.rdata, 32'd1);
        chk("ord_r1_data", data_bus.data_ok, 0);
        tick();
        mem_bus.rdata = 32'd2;
        settle();
        chk("ord_r2_data", data_bus.data_ok, 1);
        chk("ord_r2_rdata", data_bus.rdata, 32'd2);
        chk("ord_r2_inst", inst_bus.data_ok, 0);
        tick();
        mem_bus.rdata = 32'd3;
        settle();
        chk("ord_r3_inst", inst_bus.data_ok, 1);
        chk("ord_r3_data", data_bus.data_ok, 0);
        tick();
        idle_all();

        // Full: four accepted, fifth stalls until a pop has registered.
        mem_bus.addr_ok = 1'b1; inst_bus.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_bus.addr = 32'h0000_0200 + 32'(4 * i);
            settle();
            chk($sformatf("full_fill%0d_addr_ok", i), inst_bus.addr_ok, 1);
            tick();
        end
        inst_bus.addr = 32'h0000_0210;
        settle();
        chk("full_stall_mem_req", mem_bus.req, 0);
        chk("full_stall_addr_ok", inst_bus.addr_ok, 0);
        tick();
        settle();
        chk("full_stall2_mem_req", mem_bus.req, 0);
        chk("full_stall2_mem_addr", mem_bus.addr, 32'h0000_0210);
        tick();
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0000_00aa;
        settle();
        chk("full_pop_inst_data_ok", inst_bus.data_ok, 1);
        chk("full_pop_same_cycle_mem_req", mem_bus.req, 0);
        tick();
        mem_bus.data_ok = 1'b0;
        settle();
        chk("full_resume_mem_req", mem_bus.req, 1);
        chk("full_resume_addr_ok", inst_bus.addr_ok, 1);
        tick();
        idle_all();

        // Drain two of the four, then reset with two outstanding.
        mem_bus.data_ok = 1'b1;
        settle();
        chk("drain1_inst_data_ok", inst_bus.data_ok, 1);
        tick();
        settle();
        chk("drain2_inst_data_ok", inst_bus.data_ok, 1);
        tick();
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("midrst_fifo_empty", dut.fifo_empty, 1);
        tick();
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h1234_5678;
        settle();
        chk("midrst_stray_inst", inst_bus.data_ok, 0);
        chk("midrst_stray_data", data_bus.data_ok, 0);
        tick();
        idle_all();
        data_bus.req = 1'b1; data_bus.addr = 32'h8000_3000; mem_bus.addr_ok = 1'b1;
        settle();
        chk("midrst_after_addr_ok", data_bus.addr_ok, 1);
        chk("midrst_after_empty", dut.fifo_empty, 1);
        tick();
        idle_all();
        settle();
        chk("midrst_after_push", dut.fifo_empty, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
